// File: rtl/gp_axis_apb_arbiter.sv
// ---------------------------------------------------------------------------
// gp_axis_apb_arbiter
//
// Shares one AXI-Stream-to-APB bridge between N_REQ AXI-Stream requesters.
// A round-robin search picks one request beat. The beat is forwarded to the
// bridge FWD stream. The block then waits for the single bridge BWD response
// and routes it back to the requester that issued the beat. Only one
// transaction is outstanding at a time.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   req_t*_i / _o       N_REQ request streams, slice k belongs to requester k
//                       (tuser = {pwrite, paddr})
//   rsp_t*_o / _i       N_REQ response streams (tdata = prdata, tuser = pslverr)
//   m_fwd_t*            request beat towards the bridge
//   m_bwd_t*            response beat from the bridge
//   grant_o             index of the current or last granted requester
//   busy_o              high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module gp_axis_apb_arbiter #(
    parameter int N_REQ          = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_USER_WIDTH = 33,
    parameter int GW             = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,

    input  logic [N_REQ*AXI_DATA_WIDTH-1:0]    req_tdata_i,
    input  logic [N_REQ*AXI_USER_WIDTH-1:0]    req_tuser_i,
    input  logic [N_REQ-1:0]                   req_tvalid_i,
    output logic [N_REQ-1:0]                   req_tready_o,

    output logic [N_REQ*AXI_DATA_WIDTH-1:0]    rsp_tdata_o,
    output logic [N_REQ-1:0]                   rsp_tuser_o,
    output logic [N_REQ-1:0]                   rsp_tvalid_o,
    input  logic [N_REQ-1:0]                   rsp_tready_i,

    output logic [AXI_DATA_WIDTH-1:0]          m_fwd_tdata_o,
    output logic [AXI_USER_WIDTH-1:0]          m_fwd_tuser_o,
    output logic                               m_fwd_tvalid_o,
    input  logic                               m_fwd_tready_i,

    input  logic [AXI_DATA_WIDTH-1:0]          m_bwd_tdata_i,
    input  logic                               m_bwd_tuser_i,
    input  logic                               m_bwd_tvalid_i,
    output logic                               m_bwd_tready_o,

    output logic [GW-1:0]                      grant_o,
    output logic                               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    state_e                            state_q;
    logic [GW-1:0]                     ptr_q;
    logic [GW-1:0]                     grant_q;
    logic [AXI_DATA_WIDTH-1:0]         fwd_tdata_q;
    logic [AXI_USER_WIDTH-1:0]         fwd_tuser_q;
    logic                              fwd_tvalid_q;
    logic                              bwd_tready_q;
    logic                              busy_q;
    logic [N_REQ-1:0]                  rsp_tvalid_q;
    logic [N_REQ-1:0]                  rsp_tuser_q;
    logic [N_REQ*AXI_DATA_WIDTH-1:0]   rsp_tdata_q;

    logic                              win_found;
    logic [GW-1:0]                     win_idx;
    logic [N_REQ-1:0]                  win_oh;
    logic [N_REQ-1:0]                  grant_oh;
    logic [N_REQ*AXI_DATA_WIDTH-1:0]   rsp_tdata_d;
    logic [N_REQ-1:0]                  rsp_tuser_d;
    logic [GW-1:0]                     ptr_d;

    // Round-robin search: first valid requester at or after ptr_q, wrapping.
    always_comb begin : winner_search
        int idx;
        // NOTE: every variable gets a default before any conditional
        // assignment so that no latch is inferred.
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!win_found && req_tvalid_i[idx]) begin
                win_found   = 1'b1;
                win_idx     = GW'(idx);
                win_oh[idx] = 1'b1;
            end
        end
    end

    // Ready is the only combinational output: it must rise in the same
    // cycle as the winning valid so a handshake can occur on entry to IDLE.
    assign req_tready_o = (state_q == S_IDLE) ? win_oh : '0;

    // Response payload placed on the granted slice only; other slices stay 0.
    always_comb begin : rsp_route
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
        rsp_tdata_d       = '0;
        rsp_tdata_d[int'(grant_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = m_bwd_tdata_i;
        rsp_tuser_d       = grant_oh & {N_REQ{m_bwd_tuser_i}};
        ptr_d             = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    // Payload registers are reset as well, so all data outputs read 0 after
    // reset rather than stale or unknown values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            fwd_tdata_q  <= '0;
            fwd_tuser_q  <= '0;
            fwd_tvalid_q <= 1'b0;
            bwd_tready_q <= 1'b0;
            busy_q       <= 1'b0;
            rsp_tvalid_q <= '0;
            rsp_tuser_q  <= '0;
            rsp_tdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        fwd_tdata_q  <= req_tdata_i[int'(win_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                        fwd_tuser_q  <= req_tuser_i[int'(win_idx)*AXI_USER_WIDTH +: AXI_USER_WIDTH];
                        grant_q      <= win_idx;
                        fwd_tvalid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_FWD;
                    end
                end
                S_FWD: begin
                    if (m_fwd_tready_i) begin
                        fwd_tvalid_q <= 1'b0;
                        bwd_tready_q <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (m_bwd_tvalid_i) begin
                        bwd_tready_q <= 1'b0;
                        rsp_tvalid_q <= grant_oh;
                        rsp_tdata_q  <= rsp_tdata_d;
                        rsp_tuser_q  <= rsp_tuser_d;
                        state_q      <= S_RSP;
                    end
                end
                S_RSP: begin
                    // Only the granted requester's ready completes the response.
                    if (rsp_tready_i[grant_q]) begin
                        rsp_tvalid_q <= '0;
                        rsp_tdata_q  <= '0;
                        rsp_tuser_q  <= '0;
                        ptr_q        <= ptr_d;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_fwd_tdata_o  = fwd_tdata_q;
    assign m_fwd_tuser_o  = fwd_tuser_q;
    assign m_fwd_tvalid_o = fwd_tvalid_q;
    assign m_bwd_tready_o = bwd_tready_q;
    assign rsp_tvalid_o   = rsp_tvalid_q;
    assign rsp_tdata_o    = rsp_tdata_q;
    assign rsp_tuser_o    = rsp_tuser_q;
    assign grant_o        = grant_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_gp_axis_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gp_axis_apb_arbiter
//
// Drives four requesters and plays the bridge. Requesters keep their beat
// pending until granted; the expected winner is the first pending requester
// scanning round-robin from the model pointer, and every response must come
// back on that requester's slice only.
// ---------------------------------------------------------------------------
module tb_gp_axis_apb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 33;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   req_tdata_i;
    logic [N*UW-1:0]   req_tuser_i;
    logic [N-1:0]      req_tvalid_i;
    logic [N-1:0]      req_tready_o;
    logic [N*DW-1:0]   rsp_tdata_o;
    logic [N-1:0]      rsp_tuser_o;
    logic [N-1:0]      rsp_tvalid_o;
    logic [N-1:0]      rsp_tready_i;
    logic [DW-1:0]     m_fwd_tdata_o;
    logic [UW-1:0]     m_fwd_tuser_o;
    logic              m_fwd_tvalid_o;
    logic              m_fwd_tready_i;
    logic [DW-1:0]     m_bwd_tdata_i;
    logic              m_bwd_tuser_i;
    logic              m_bwd_tvalid_i;
    logic              m_bwd_tready_o;
    logic [GW-1:0]     grant_o;
    logic              busy_o;

    gp_axis_apb_arbiter #(
        .N_REQ          (N),
        .AXI_DATA_WIDTH (DW),
        .AXI_USER_WIDTH (UW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_tdata_i    (req_tdata_i),
        .req_tuser_i    (req_tuser_i),
        .req_tvalid_i   (req_tvalid_i),
        .req_tready_o   (req_tready_o),
        .rsp_tdata_o    (rsp_tdata_o),
        .rsp_tuser_o    (rsp_tuser_o),
        .rsp_tvalid_o   (rsp_tvalid_o),
        .rsp_tready_i   (rsp_tready_i),
        .m_fwd_tdata_o  (m_fwd_tdata_o),
        .m_fwd_tuser_o  (m_fwd_tuser_o),
        .m_fwd_tvalid_o (m_fwd_tvalid_o),
        .m_fwd_tready_i (m_fwd_tready_i),
        .m_bwd_tdata_i  (m_bwd_tdata_i),
        .m_bwd_tuser_i  (m_bwd_tuser_i),
        .m_bwd_tvalid_i (m_bwd_tvalid_i),
        .m_bwd_tready_o (m_bwd_tready_o),
        .grant_o        (grant_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int              model_ptr;
    bit              pending [N];
    logic [DW-1:0]   q_data  [N];
    logic [UW-1:0]   q_user  [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            req_tvalid_i[k]            = pending[k];
            req_tdata_i[k*DW +: DW]    = q_data[k];
            req_tuser_i[k*UW +: UW]    = q_user[k];
        end
    endtask

    task automatic add_req(input int k, input logic [DW-1:0] d, input logic [UW-1:0] u);
        if (!pending[k]) begin
            pending[k] = 1'b1;
            q_data[k]  = d;
            q_user[k]  = u;
        end
    endtask

    task automatic add_random(input int mask);
        for (int k = 0; k < N; k++)
            if (mask[k]) add_req(k, $urandom, {1'($urandom_range(0, 1)), 32'($urandom)});
    endtask

    function automatic int exp_winner();
        for (int i = 0; i < N; i++)
            if (pending[(model_ptr + i) % N]) return (model_ptr + i) % N;
        return 0;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        m_fwd_tready_i = 1'b0;
        m_bwd_tvalid_i = 1'b0;
        m_bwd_tdata_i  = '0;
        m_bwd_tuser_i  = 1'b0;
        rsp_tready_i   = '0;
        for (int k = 0; k < N; k++) begin
            pending[k] = 1'b0;
            q_data[k]  = '0;
            q_user[k]  = '0;
        end
        drive_reqs();
        model_ptr = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // One full transaction: grant, forward, bridge response, return.
    task automatic run_txn(input int fwd_delay, input int rsp_delay, input bit early_bwd,
                           input int bwd_delay, input logic [DW-1:0] bdata, input bit berr,
                           output int winner);
        int            w;
        logic [N-1:0]  oh;
        logic [N*DW-1:0] exp_rd;
        drive_reqs();
        #1;
        w      = exp_winner();
        winner = w;
        oh     = '0;
        oh[w]  = 1'b1;
        exp_rd = '0;
        exp_rd[w*DW +: DW] = bdata;
        check("idle_busy", busy_o, 0);
        check("idle_req_tready", req_tready_o, oh);

        tick();                                   // request handshake
        check("fwd_tvalid", m_fwd_tvalid_o, 1);
        check("fwd_tdata", m_fwd_tdata_o, q_data[w]);
        check("fwd_tuser", m_fwd_tuser_o, q_user[w]);
        check("fwd_grant", grant_o, w);
        check("fwd_busy", busy_o, 1);
        check("fwd_req_tready", req_tready_o, 0);
        pending[w] = 1'b0;
        drive_reqs();

        m_bwd_tvalid_i = early_bwd;
        m_bwd_tdata_i  = bdata;
        m_bwd_tuser_i  = berr;
        for (int c = 0; c < fwd_delay; c++) begin
            tick();
            check("fwd_hold_tvalid", m_fwd_tvalid_o, 1);
            check("fwd_hold_tdata", m_fwd_tdata_o, q_data[w]);
            check("fwd_hold_tuser", m_fwd_tuser_o, q_user[w]);
            check("fwd_bwd_tready", m_bwd_tready_o, 0);
            check("fwd_hold_busy", busy_o, 1);
            check("fwd_hold_req_tready", req_tready_o, 0);
        end
        m_fwd_tready_i = 1'b1;
        tick();                                   // FWD handshake
        m_fwd_tready_i = 1'b0;
        check("wait_fwd_tvalid", m_fwd_tvalid_o, 0);
        check("wait_bwd_tready", m_bwd_tready_o, 1);
        check("wait_rsp_tvalid", rsp_tvalid_o, 0);

        if (!early_bwd) begin
            for (int c = 0; c < bwd_delay; c++) begin
                tick();
                check("wait_hold_bwd_tready", m_bwd_tready_o, 1);
                check("wait_hold_rsp_tvalid", rsp_tvalid_o, 0);
            end
        end
        m_bwd_tvalid_i = 1'b1;
        tick();                                   // BWD handshake
        m_bwd_tvalid_i = 1'b0;
        m_bwd_tdata_i  = ~bdata;
        m_bwd_tuser_i  = ~berr;
        check("rsp_tvalid", rsp_tvalid_o, oh);
        check("rsp_tdata", rsp_tdata_o, exp_rd);
        check("rsp_tuser", rsp_tuser_o, berr ? oh : '0);
        check("rsp_bwd_tready", m_bwd_tready_o, 0);
        check("rsp_busy", busy_o, 1);

        for (int c = 0; c < rsp_delay; c++) begin
            rsp_tready_i = ~oh;                   // non-granted readies must be ignored
            tick();
            check("rsp_hold_tvalid", rsp_tvalid_o, oh);
            check("rsp_hold_tdata", rsp_tdata_o, exp_rd);
            check("rsp_hold_busy", busy_o, 1);
            check("rsp_hold_req_tready", req_tready_o, 0);
        end
        rsp_tready_i = oh;
        tick();                                   // response handshake
        rsp_tready_i = '0;
        check("done_rsp_tvalid", rsp_tvalid_o, 0);
        check("done_rsp_tdata", rsp_tdata_o, 0);
        check("done_busy", busy_o, 0);
        model_ptr = (w + 1) % N;
    endtask

    initial begin
        int w;
        int rr_order [6];
        rr_order = '{0, 1, 2, 3, 0, 1};

        // Reset state.
        do_reset();
        check("rst_busy", busy_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_fwd_tvalid", m_fwd_tvalid_o, 0);
        check("rst_bwd_tready", m_bwd_tready_o, 0);
        check("rst_rsp_tvalid", rsp_tvalid_o, 0);
        check("rst_fwd_tdata", m_fwd_tdata_o, 0);
        check("rst_rsp_tdata", rsp_tdata_o, 0);

        // Idle with no request.
        tick();
        check("noreq_req_tready", req_tready_o, 0);
        check("noreq_busy", busy_o, 0);

        // Single requester 1.
        add_req(1, 32'hDEAD_BEEF, {1'b1, 32'h0000_0010});
        run_txn(0, 0, 1'b0, 0, 32'h1234_5678, 1'b0, w);
        check("single_grant", w, 1);

        // Round-robin fairness with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            add_random(4'hF);
            run_txn(0, 0, 1'b0, 0, $urandom, 1'b0, w);
            check("rr_order", w, rr_order[i]);
        end

        // Pointer skip: grant 2 leaves ptr=3; only req 1 then wins; ptr becomes 2.
        do_reset();
        add_random(4'b0100);
        run_txn(0, 0, 1'b0, 0, $urandom, 1'b0, w);
        check("skip_grant2", w, 2);
        add_random(4'b0010);
        run_txn(0, 0, 1'b0, 0, $urandom, 1'b0, w);
        check("skip_grant1", w, 1);
        add_random(4'b0110);
        run_txn(0, 0, 1'b0, 0, $urandom, 1'b0, w);
        check("skip_ptr2", w, 2);

        // Backpressure on FWD and RSP with an early BWD beat during FWD.
        add_random(4'b1001);
        run_txn(5, 5, 1'b1, 0, 32'hA5A5_0F0F, 1'b0, w);
        check("bp_grant", w, 3);

        // Error response.
        run_txn(0, 0, 1'b0, 1, 32'h0, 1'b1, w);
        check("err_grant", w, 0);

        // Asynchronous reset while waiting for the bridge.
        add_random(4'b0100);
        drive_reqs();
        tick();                                   // grant 2
        pending[2] = 1'b0;
        drive_reqs();
        m_fwd_tready_i = 1'b1;
        tick();
        m_fwd_tready_i = 1'b0;
        check("arst_in_wait", m_bwd_tready_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_bwd_tready", m_bwd_tready_o, 0);
        check("arst_grant", grant_o, 0);
        check("arst_fwd_tvalid", m_fwd_tvalid_o, 0);
        check("arst_fwd_tuser", m_fwd_tuser_o, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("arst_rsp_tvalid", rsp_tvalid_o, 0);
        end
        rst       = 1'b0;
        model_ptr = 0;
        add_random(4'b1010);
        run_txn(0, 0, 1'b0, 0, $urandom, 1'b0, w);
        check("arst_restart_grant", w, 1);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            add_random($urandom_range(1, 15));
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
